// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the four digit buses of the seven-segment display driver. Results are
// registered and only change on the FINISH edge, so the display never flickers
// while a new conversion is running.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [BIN_W-1:0] BIN,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF,
    output logic [3:0]       BCD0,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD3
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    // Counter value seen during the last shift iteration.
    localparam logic [3:0] LAST_CNT = 4'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shiftReg_q, shiftReg_d;
    logic [19:0]        scratch_q, scratch_d;
    logic [3:0]         bitCnt_q, bitCnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [19:0]        adjusted;

    // The top digit of a 14-bit value never exceeds 1, so the bit shifted out
    // of the scratch register is always zero and is deliberately dropped.
    logic               unusedTopBit;
    assign unusedTopBit = adjusted[19];

    // Add 3 to every scratch digit that is 5 or more, all five in parallel.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/SHIFT/FINISH sequencer.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        scratch_d  = scratch_q;
        bitCnt_d   = bitCnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    shiftReg_d = BIN;
                    scratch_d  = '0;
                    bitCnt_d   = '0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                scratch_d  = {adjusted[18:0], shiftReg_q[BIN_W-1]};
                shiftReg_d = {shiftReg_q[BIN_W-2:0], 1'b0};
                bitCnt_d   = bitCnt_q + 4'd1;
                if (bitCnt_q == LAST_CNT) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                ovf_d = (scratch_q[19:16] != 4'd0);
                if (ovf_d && SAT_EN) begin
                    bcd_d = 16'h9999;
                end else begin
                    bcd_d = scratch_q[15:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            scratch_q  <= '0;
            bitCnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            scratch_q  <= scratch_d;
            bitCnt_q   <= bitCnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign OVF  = ovf_q;
    assign BCD0 = bcd_q[3:0];
    assign BCD1 = bcd_q[7:4];
    assign BCD2 = bcd_q[11:8];
    assign BCD3 = bcd_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq. Two instances share all inputs: one
// saturating, one showing the value modulo 10000. Stimulus pushes the
// hand-computed result for each instance; monitors pop on every DONE.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        CLK;
    logic        RSTN;
    logic [13:0] BIN;
    logic        START;
    logic        busySat, doneSat, ovfSat;
    logic [3:0]  satBcd0, satBcd1, satBcd2, satBcd3;
    logic        busyWrap, doneWrap, ovfWrap;
    logic [3:0]  wrapBcd0, wrapBcd1, wrapBcd2, wrapBcd3;

    exp_t satQ[$];
    exp_t wrapQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    bin_to_bcd_seq #(.BIN_W(14), .SAT_EN(1'b1)) dutSat (
        .CLK(CLK), .RSTN(RSTN), .BIN(BIN), .START(START),
        .BUSY(busySat), .DONE(doneSat), .OVF(ovfSat),
        .BCD0(satBcd0), .BCD1(satBcd1), .BCD2(satBcd2), .BCD3(satBcd3)
    );

    bin_to_bcd_seq #(.BIN_W(14), .SAT_EN(1'b0)) dutWrap (
        .CLK(CLK), .RSTN(RSTN), .BIN(BIN), .START(START),
        .BUSY(busyWrap), .DONE(doneWrap), .OVF(ovfWrap),
        .BCD0(wrapBcd0), .BCD1(wrapBcd1), .BCD2(wrapBcd2), .BCD3(wrapBcd3)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Saturating-instance monitor: every DONE must match the oldest expectation.
    always @(negedge CLK) begin
        if (doneSat === 1'b1) begin
            if (satQ.size() == 0) begin
                checkOutput("unexpectedDoneSat", 1, 0);
            end else begin
                exp_t e;
                e = satQ.pop_front();
                checkOutput("satBcd", int'({satBcd3, satBcd2, satBcd1, satBcd0}), int'(e.bcd));
                checkOutput("satOvf", int'(ovfSat), int'(e.ovf));
            end
        end
    end

    // Modulo-instance monitor, same pattern.
    always @(negedge CLK) begin
        if (doneWrap === 1'b1) begin
            if (wrapQ.size() == 0) begin
                checkOutput("unexpectedDoneWrap", 1, 0);
            end else begin
                exp_t e;
                e = wrapQ.pop_front();
                checkOutput("wrapBcd", int'({wrapBcd3, wrapBcd2, wrapBcd1, wrapBcd0}), int'(e.bcd));
                checkOutput("wrapOvf", int'(ovfWrap), int'(e.ovf));
            end
        end
    end

    // Called #1 after the accepting edge. Counts edges from E0 up to the DONE
    // cycle, BUSY cycles, and changes of the saturating display while busy.
    // Optionally raises START with a new BIN at a given BUSY cycle.
    task automatic waitDone(input int injectAt, input logic [13:0] injectBin,
                            input logic [15:0] prevBcd,
                            output int edges, output int busyCycles, output int changes);
        edges      = 1;
        busyCycles = 0;
        changes    = 0;
        for (int k = 0; k < 60; k++) begin
            if (doneSat === 1'b1) break;
            if (busySat === 1'b1) busyCycles++;
            if ({satBcd3, satBcd2, satBcd1, satBcd0} !== prevBcd) changes++;
            if (injectAt != 0) begin
                if (busyCycles == injectAt) begin
                    START = 1'b1;
                    BIN   = injectBin;
                end else begin
                    START = 1'b0;
                end
            end
            @(posedge CLK);
            #1;
            edges++;
        end
    endtask

    // Issues one START pulse and checks latency, BUSY length and display stability.
    task automatic applyStimulus(input logic [13:0] value, input logic [15:0] expSat,
                                 input logic [15:0] expWrap, input logic expOvf,
                                 input logic [15:0] prevBcd, input int injectAt,
                                 input logic [13:0] injectBin);
        int edges, busyCycles, changes;
        satQ.push_back('{bcd: expSat, ovf: expOvf});
        wrapQ.push_back('{bcd: expWrap, ovf: expOvf});
        BIN   = value;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        waitDone(injectAt, injectBin, prevBcd, edges, busyCycles, changes);
        checkOutput("doneLatency", edges, 16);
        checkOutput("busyCycles", busyCycles, 15);
        checkOutput("displayStable", changes, 0);
    endtask

    // Counts DONE pulses of either instance over a window of cycles.
    task automatic countDones(input int cycles, output int dones);
        dones = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge CLK);
            #1;
            if (doneSat === 1'b1 || doneWrap === 1'b1) dones++;
        end
    endtask

    // Directed test sequence.
    initial begin
        int edges, busyCycles, changes, dones;
        RSTN  = 1'b0;
        BIN   = '0;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("resetBusy", int'(busySat), 0);
        checkOutput("resetDone", int'(doneSat), 0);
        checkOutput("resetOvf", int'(ovfSat), 0);
        checkOutput("resetBcd", int'({satBcd3, satBcd2, satBcd1, satBcd0}), 0);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] zero conversion");
        applyStimulus(14'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0, '0);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] 1234 conversion");
        applyStimulus(14'd1234, 16'h1234, 16'h1234, 1'b0, 16'h0000, 0, '0);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] 16383 overflow");
        applyStimulus(14'd16383, 16'h9999, 16'h6383, 1'b1, 16'h1234, 0, '0);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] 9999 with ignored START");
        applyStimulus(14'd9999, 16'h9999, 16'h9999, 1'b0, 16'h9999, 5, 14'd5);
        START = 1'b0;
        countDones(25, dones);
        checkOutput("ignoredStartDones", dones, 0);

        $display("[TB] START held, 42 then 43");
        satQ.push_back('{bcd: 16'h0042, ovf: 1'b0});
        wrapQ.push_back('{bcd: 16'h0042, ovf: 1'b0});
        satQ.push_back('{bcd: 16'h0043, ovf: 1'b0});
        wrapQ.push_back('{bcd: 16'h0043, ovf: 1'b0});
        BIN   = 14'd42;
        START = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        BIN = 14'd43;
        waitDone(0, '0, 16'h9999, edges, busyCycles, changes);
        checkOutput("heldFirstLatency", edges + 1, 16);
        @(posedge CLK);
        #1;
        START = 1'b0;
        checkOutput("heldRetriggerBusy", int'(busySat), 1);
        waitDone(0, '0, 16'h0042, edges, busyCycles, changes);
        checkOutput("heldSecondLatency", edges, 16);
        repeat (2) @(posedge CLK);
        #1;

        $display("[TB] reset mid-conversion");
        BIN   = 14'd777;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        checkOutput("midBusy", int'(busySat), 1);
        RSTN = 1'b0;
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        checkOutput("abortBusy", int'(busySat), 0);
        checkOutput("abortDone", int'(doneSat), 0);
        checkOutput("abortOvf", int'(ovfSat), 0);
        checkOutput("abortBcd", int'({satBcd3, satBcd2, satBcd1, satBcd0}), 0);
        checkOutput("abortWrapBcd", int'({wrapBcd3, wrapBcd2, wrapBcd1, wrapBcd0}), 0);
        countDones(25, dones);
        checkOutput("abortNoDone", dones, 0);

        checkOutput("satQueueEmpty", satQ.size(), 0);
        checkOutput("wrapQueueEmpty", wrapQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces the four BCD digit buses consumed by the 4-digit seven-segment display driver on the Basys board.
- Sits between arithmetic/counter logic (binary domain) and the display path (BCD domain). Provides a start/busy/done handshake and overflow indication for values above 9999.

Parameters:
- BIN_W, 14, width of binary input; legal range 4..14.
- SAT_EN, 1, 1 = saturate display to 9999 on overflow; 0 = show the value modulo 10000.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RSTN  input  1  synchronous reset, active-low.
- BIN  input  BIN_W  unsigned binary value; sampled only on the accepting START edge.
- START  input  1  conversion request; level-sampled, accepted only in IDLE.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when new results are valid.
- OVF  output  1  result exceeded 9999; valid with DONE, held until the next DONE.
- BCD0  output  4  ones digit.
- BCD1  output  4  tens digit.
- BCD2  output  4  hundreds digit.
- BCD3  output  4  thousands digit.

Behaviour:
- Reset: RSTN low at a rising edge forces the following, regardless of current state:
  - state = IDLE
  - BUSY = 0, DONE = 0, OVF = 0
  - BCD0..BCD3 = 0
  - internal shift register and bit counter cleared
  - an in-progress conversion is abandoned with no DONE.
- Internal storage:
  - binary shift register, BIN_W bits
  - scratch register, 20 bits (5 digits D4..D0)
  - bit counter, 4 bits.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If START = 1 at edge E0: load BIN into the shift register, clear scratch, counter = 0, BUSY <= 1, go to SHIFT.
  - Otherwise hold.
- SHIFT, one edge per iteration:
  - For each scratch digit >= 5, add 3 (all five digits in parallel, combinational).
  - Then shift {scratch, shiftreg} left by 1; counter += 1.
  - After the BIN_W-th shift (edge E_BIN_W), go to FINISH.
- FINISH, at edge E_BIN_W+1:
  - OVF <= (D4 != 0).
  - If OVF and SAT_EN = 1: BCD3..BCD0 <= 9,9,9,9.
  - Otherwise: BCD3..BCD0 <= D3..D0.
  - DONE <= 1 for exactly one cycle, BUSY <= 0, go to IDLE.
- Latency: with the default BIN_W = 14, DONE is high in the cycle after E15, i.e. 16 edges after E0 inclusive. BUSY is high for cycles E0+ .. E14+.
- Outputs BCD0..3 and OVF hold their previous result throughout a conversion and change only on the FINISH edge, so there is no display flicker.
- START while BUSY is ignored: no queueing, no effect on the running conversion.
- START high in the cycle where DONE is high is accepted, because the state is already IDLE. This gives back-to-back conversions with a period of BIN_W + 2 cycles.
- START held high continuously retriggers on every IDLE cycle.
- All arithmetic is unsigned. Digits never exceed 9 at output.

Test Plan:
- Reset, then BIN = 0 with START pulsed 1 cycle:
  - BUSY high 15 cycles.
  - DONE pulse 16 edges after the START edge.
  - BCD3..0 = 0,0,0,0; OVF = 0.
- BIN = 1234 (14'h04D2), START:
  - BCD3 = 1, BCD2 = 2, BCD1 = 3, BCD0 = 4; OVF = 0.
  - The previous result (0000) stays stable until the DONE cycle.
- BIN = 16383 with SAT_EN = 1 → BCD = 9,9,9,9, OVF = 1. Same input with SAT_EN = 0 → BCD = 6,3,8,3, OVF = 1.
- BIN = 9999, START; then BIN changes to 5 and START pulses at the 5th BUSY cycle:
  - Result is 9,9,9,9 with OVF = 0.
  - Exactly one DONE pulse; the second START is ignored.
- START held high with BIN = 42 then 43 (changed during busy):
  - First DONE gives 0,0,4,2.
  - Second conversion starts in the DONE cycle; second DONE arrives 16 edges later and gives 0,0,4,3.
- Reset mid-conversion: START with BIN = 777, RSTN low at the 8th BUSY cycle:
  - Next cycle BUSY = 0, DONE = 0, BCD = 0000, OVF = 0.
  - No DONE follows.
